// File: rtl/multi_byte_adder_seq.sv
// Byte-serial wide adder: drives one shared external 8-bit adder, LSB byte first.
// Optional subtract support is compiled in with `define MBA_SUB_EN.
module multi_byte_adder_seq #(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*N_BYTES-1:0]   a,
    input  logic [8*N_BYTES-1:0]   b,
    input  logic                   cin,
`ifdef MBA_SUB_EN
    input  logic                   sub,
`endif
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout,
    output logic                   busy,
    output logic                   done,
    output logic [8*N_BYTES-1:0]   sum,
    output logic                   cout,
    output logic                   zero
);

    localparam int unsigned W     = 8 * N_BYTES;
    localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               last_byte;

    assign last_byte = (idx_q == IDX_W'(N_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_byte) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_RUN: begin
                add_a   = a_q[8*idx_q +: 8];
                add_b   = b_q[8*idx_q +: 8];
                add_cin = c_q;
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        idx_d  = idx_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        zero_d = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    c_d   = cin;
                    idx_d = '0;
`ifdef MBA_SUB_EN
                    // a - b as a + ~b + 1: invert once at latch time, force carry-in
                    if (sub) begin
                        b_d = ~b;
                        c_d = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                sum_d[8*idx_q +: 8] = add_sum;
                c_d   = add_cout;
                idx_d = idx_q + 1'b1;
                if (last_byte) begin
                    cout_d = add_cout;
                    zero_d = (sum_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_multi_byte_adder_seq.sv
// Directed and random bench for multi_byte_adder_seq with a behavioural 8-bit adder.
module tb_multi_byte_adder_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub_drv = 1'b0;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    multi_byte_adder_seq #(.N_BYTES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef MBA_SUB_EN
        .sub      (sub_drv),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .zero     (zero)
    );

    // Issues one operation and waits for done; lat = cycles from accepting edge
    // to the done cycle (-1 on timeout), chain_err counts busy drops and carry breaks.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, output int lat, output int chain_err);
        logic prev_cout;
        bit   first;
        @(negedge clk);
        a = op_a; b = op_b; cin = op_cin; start = 1'b1;
        lat = -1; chain_err = 0; first = 1'b1; prev_cout = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) chain_err++;
            if (!first && add_cin !== prev_cout) chain_err++;
            prev_cout = add_cout;
            first = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({sum, cout, zero, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sum=%h cout=%b zero=%b busy=%b done=%b, want all 0",
                     sum, cout, zero, busy, done);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL reset_adder_if: add_a=%h add_b=%h add_cin=%b, want 0", add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b want 0", busy);
        end
    endtask

    task automatic test_carry_ripple();
        int lat, ce;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, ce);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL ripple_latency: got %0d want 5", lat); end
        checks++;
        if (ce != 0) begin errors++; $display("FAIL ripple_chain_busy: got %0d errs want 0", ce); end
        checks++;
        if (sum !== 32'h0000_0100) begin errors++; $display("FAIL ripple_sum: got %h want 00000100", sum); end
        checks++;
        if (cout !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL ripple_flags: cout=%b zero=%b want 0 0", cout, zero);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL done_busy: busy=%b want 1", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width: done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (sum !== 32'h0000_0100) begin errors++; $display("FAIL sum_hold: got %h want 00000100", sum); end
    endtask

    task automatic test_full_wrap();
        int lat, ce;
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat, ce);
        checks++;
        if (lat != 5 || ce != 0) begin errors++; $display("FAIL wrap_timing: lat=%0d chain=%0d want 5 0", lat, ce); end
        checks++;
        if (sum !== 32'h0 || cout !== 1'b1 || zero !== 1'b1) begin
            errors++; $display("FAIL wrap_result: sum=%h cout=%b zero=%b want 00000000 1 1", sum, cout, zero);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int dones;
        @(negedge clk);
        a = 32'h0000_00F0; b = 32'h0000_0010; cin = 1'b0; start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || sum !== 32'h0000_0100) begin
            errors++; $display("FAIL b2b_first: seen=%0d sum=%h want 1 00000100", seen, sum);
        end
        // operands present only at the DONE-leaving edge must not be taken
        a = 32'h0000_0001; b = 32'h0000_0001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", busy, done);
        end
        a = 32'h0000_1000; b = 32'h0000_0234; cin = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                checks++;
                if (sum !== 32'h0000_1235 || cout !== 1'b0) begin
                    errors++; $display("FAIL b2b_second_sum: sum=%h cout=%b want 00001235 0", sum, cout);
                end
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid_run();
        int lat, ce, dones;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (sum[7:0] !== 8'h89 || busy !== 1'b1) begin
            errors++; $display("FAIL midrun_partial: sum=%h busy=%b want ......89 1", sum, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sum, cout, zero, busy, done, add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL midrun_async_clear: sum=%h busy=%b add_a=%h add_b=%h add_cin=%b want 0",
                     sum, busy, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL midrun_no_done: activity=%0d want 0", dones); end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, ce);
        checks++;
        if (lat != 5 || sum !== 32'h2345_6789 || cout !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_recover: lat=%0d sum=%h cout=%b zero=%b want 5 23456789 0 0",
                     lat, sum, cout, zero);
        end
    endtask

`ifdef MBA_SUB_EN
    task automatic test_sub();
        int lat, ce;
        sub_drv = 1'b1;
        run_op(32'd5, 32'd7, 1'b0, lat, ce);
        checks++;
        if (sum !== 32'hFFFF_FFFE || cout !== 1'b0 || ce != 0) begin
            errors++; $display("FAIL sub_borrow: sum=%h cout=%b chain=%0d want fffffffe 0 0", sum, cout, ce);
        end
        run_op(32'd7, 32'd5, 1'b0, lat, ce);
        checks++;
        if (sum !== 32'h0000_0002 || cout !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow: sum=%h cout=%b want 00000002 1", sum, cout);
        end
        sub_drv = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int lat, ce;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            if (i % 7 == 0) rb = ~ra;
`ifdef MBA_SUB_EN
            sub_drv = 1'($urandom_range(1));
            if (i % 11 == 0) rb = ra;
`endif
            if (sub_drv) exp = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
            else         exp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            run_op(ra, rb, rc, lat, ce);
            checks++;
            if (lat != 5 || ce != 0) begin
                errors++; $display("FAIL rand_timing[%0d]: lat=%0d chain=%0d want 5 0", i, lat, ce);
            end
            checks++;
            if ({cout, sum} !== exp || zero !== (exp[W-1:0] == '0)) begin
                errors++;
                $display("FAIL rand_result[%0d]: a=%h b=%h cin=%b sub=%b got %b_%h zero=%b want %b_%h",
                         i, ra, rb, rc, sub_drv, cout, sum, zero, exp[W], exp[W-1:0]);
            end
        end
        sub_drv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MBA_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
